joy_db9_conditioner: RTL

JOY_DB9_CONDITIONER -- requirements
Module: joy_db9_conditioner

---
 rtl/joy_db9_conditioner.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/joy_db9_conditioner.sv
// joy_db9_conditioner
//
// Conditions the 24 button lines coming from a DB9 splitter decoder (two
// players, 12 buttons each) into clean, debounced state plus a change-event
// stream for a software or bus consumer.
//
// Each raw bit is synchronised through two flops, then debounced. The
// debounced ("stable") bit only toggles after DB_CYCLES consecutive cycles in
// which the synchronised value differs from it. Every toggle is recorded in a
// per-player pending mask, and the pending masks are drained one at a time
// into a single output event slot, alternating between players when both
// have something to report.
//
// Ports
//   clk          in   single rising-edge clock
//   reset_n      in   asynchronous active-low reset
//   joy1_raw     in   [11:0] player 1 buttons, M S Z Y X C B A U D L R (11..0)
//   joy2_raw     in   [11:0] player 2 buttons, same format
//   joy1         out  [11:0] player 1 debounced state
//   joy2         out  [11:0] player 2 debounced state
//   evt_valid    out  change event available
//   evt_ready    in   consumer accepts the event
//   evt_player   out  0 = player 1, 1 = player 2
//   evt_mask     out  [11:0] bits that changed since that player's previous event
//   evt_state    out  [11:0] that player's debounced state when the event was loaded
//   evt_overflow out  sticky: a change was lost because its bit was still pending
//
// Event handshake: an event transfers on a rising edge where evt_valid and
// evt_ready are both high. While evt_valid is high and evt_ready is low,
// evt_player/evt_mask/evt_state hold. evt_ready is ignored while evt_valid is
// low. A new event may be loaded on the same edge as a transfer, so one event
// per cycle is possible while evt_ready stays high.
module joy_db9_conditioner #(
  parameter int unsigned DB_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [11:0] joy1_raw,
  input  logic [11:0] joy2_raw,
  output logic [11:0] joy1,
  output logic [11:0] joy2,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic        evt_player,
  output logic [11:0] evt_mask,
  output logic [11:0] evt_state,
  output logic        evt_overflow
);

  localparam int unsigned CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  // Bits 11..0 belong to player 1, bits 23..12 to player 2.
  logic [23:0]   raw_w;
  logic [23:0]   sync1_q;
  logic [23:0]   sync2_q;
  logic [23:0]   stable_q;
  logic [23:0]   stable_d;
  logic [23:0]   toggle_w;
  logic [CW-1:0] cnt_q [24];
  logic [CW-1:0] cnt_d [24];

  logic [11:0]   pend1_q, pend1_d;
  logic [11:0]   pend2_q, pend2_d;
  logic          next_q, next_d;      // player preferred when both are pending
  logic          evt_valid_q, evt_valid_d;
  logic          evt_player_q, evt_player_d;
  logic [11:0]   evt_mask_q, evt_mask_d;
  logic [11:0]   evt_state_q, evt_state_d;
  logic          ovf_q, ovf_d;

  logic          slot_free_w;
  logic          has1_w, has2_w;
  logic          sel_w;
  logic          load_w;
  logic          clr1_w, clr2_w;

  assign raw_w = {joy2_raw, joy1_raw};

  // Debounce: count consecutive cycles of disagreement; any agreement
  // restarts the count, so a glitch shorter than DB_CYCLES never toggles.
  always_comb begin
    toggle_w = '0;
    for (int i = 0; i < 24; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          toggle_w[i] = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
    stable_d = stable_q ^ toggle_w;
  end

  // Event slot and pending masks.
  always_comb begin
    slot_free_w = ~evt_valid_q | evt_ready;
    has1_w      = |pend1_q;
    has2_w      = |pend2_q;
    // With only one player pending, serve that one; with both, alternate.
    sel_w       = (has1_w && has2_w) ? next_q : has2_w;
    load_w      = slot_free_w && (has1_w || has2_w);
    clr1_w      = load_w && !sel_w;
    clr2_w      = load_w && sel_w;

    evt_valid_d  = evt_valid_q;
    evt_player_d = evt_player_q;
    evt_mask_d   = evt_mask_q;
    evt_state_d  = evt_state_q;
    next_d       = next_q;

    if (load_w) begin
      evt_valid_d  = 1'b1;
      evt_player_d = sel_w;
      evt_mask_d   = sel_w ? pend2_q : pend1_q;
      evt_state_d  = sel_w ? stable_d[23:12] : stable_d[11:0];
      next_d       = ~sel_w;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d  = 1'b0;
    end

    // A toggle during the load of its own player lands in the freshly
    // cleared mask, so it is neither merged into the event nor lost.
    pend1_d = (clr1_w ? 12'h000 : pend1_q) | toggle_w[11:0];
    pend2_d = (clr2_w ? 12'h000 : pend2_q) | toggle_w[23:12];

    // A change is lost only when its bit is still pending and that pending
    // mask is not leaving for the event slot on this edge.
    ovf_d = ovf_q
          | (|(toggle_w[11:0]  & pend1_q & {12{~clr1_w}}))
          | (|(toggle_w[23:12] & pend2_q & {12{~clr2_w}}));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      stable_q     <= '0;
      for (int i = 0; i < 24; i++) begin
        cnt_q[i] <= '0;
      end
      pend1_q      <= '0;
      pend2_q      <= '0;
      next_q       <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_player_q <= 1'b0;
      evt_mask_q   <= '0;
      evt_state_q  <= '0;
      ovf_q        <= 1'b0;
    end else begin
      sync1_q      <= raw_w;
      sync2_q      <= sync1_q;
      stable_q     <= stable_d;
      for (int i = 0; i < 24; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      pend1_q      <= pend1_d;
      pend2_q      <= pend2_d;
      next_q       <= next_d;
      evt_valid_q  <= evt_valid_d;
      evt_player_q <= evt_player_d;
      evt_mask_q   <= evt_mask_d;
      evt_state_q  <= evt_state_d;
      ovf_q        <= ovf_d;
    end
  end

  assign joy1         = stable_q[11:0];
  assign joy2         = stable_q[23:12];
  assign evt_valid    = evt_valid_q;
  assign evt_player   = evt_player_q;
  assign evt_mask     = evt_mask_q;
  assign evt_state    = evt_state_q;
  assign evt_overflow = ovf_q;

endmodule
